gobou_readout: RTL and testbench
================================

Name: gobou_readout

Overview:
- Result-drain engine for the gobou fully-connected accelerator. It is the read side of the image memory that the host load path writes.
- On `start` (normally wired to gobou_top's `ack`), it reads `count` result words from image memory, beginning at `base_addr`.
- It emits those words on a valid/ready output stream. Last word is flagged. A `done` pulse fires when the final word is accepted.
- Replaces the bench's direct hierarchical peek of memory contents.

Parameters:
- DWIDTH, 16, data word width (matches gobou DWIDTH).
- IMGSIZE, 12, image memory address width.
- LWIDTH, 10, word-count width (matches gobou LWIDTH).
- FDEPTH, 2, output FIFO depth; minimum 2, which gives full throughput.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request pulse.
- base_addr  in  IMGSIZE  first read address; sampled on start.
- count  in  LWIDTH  number of words to read; sampled on start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the final stream handshake.
- mem_re  out  1  memory read enable.
- mem_addr  out  IMGSIZE  memory read address.
- read_img  in  DWIDTH signed  read data; valid exactly 1 cycle after mem_re.
- out_valid  out  1  stream valid.
- out_data  out  DWIDTH signed  stream data.
- out_last  out  1  high with the final word.
- out_ready  in  1  stream ready from the consumer.

Behaviour:
- Reset state: all outputs 0; FSM in IDLE; FIFO empty; in-flight flag cleared. Reset asserted mid-transfer aborts it immediately: no done pulse, stale read data discarded.
- FSM states: IDLE, READ, DRAIN.
  - IDLE: start=1 latches base_addr and count.
    - count=0: go to DONE-pulse path. done=1 on the next cycle; busy stays 0; no mem_re.
    - count>0: go to READ.
  - READ: issue reads. When the remaining-issue counter reaches 0, go to DRAIN.
  - DRAIN: wait until the FIFO is empty and no read is in flight. Then done=1 for 1 cycle and return to IDLE.
- start outside IDLE is ignored.
- Read-issue rule:
  - mem_re=1 only in READ, and only when FIFO occupancy + in-flight − pop_this_cycle < FDEPTH.
  - pop_this_cycle = out_valid & out_ready.
  - The FIFO must never overflow.
- Address handling: mem_addr increments by 1 per issued read, modulo 2^IMGSIZE (wraps, no error). mem_addr holds its value when mem_re=0.
- Capture: read_img is written into the FIFO on the edge ending the cycle after mem_re. out_valid is a registered FIFO-not-empty.
- Latency: start sampled at edge 0; mem_re high in cycle 1; read_img valid in cycle 2; out_valid high in cycle 3.
- Throughput: with out_ready held high, 1 word per cycle.
- Backpressure: while out_valid=1 & out_ready=0, out_data and out_last hold stable.
- out_last is tagged per word when the word is issued: it is set on the word whose issue index equals count−1.
- Completion: done asserts in the cycle after the handshake of the out_last word. busy falls in the same cycle that done rises.
- Width rules: internal issue and pop counters are LWIDTH bits. count up to 2^LWIDTH−1 is supported.

Decomposition:
- Shared package (gobou.svh): DWIDTH, IMGSIZE, LWIDTH, and a readout state enum (S_IDLE, S_READ, S_DRAIN).
- One sub-module: gobou_readout_fifo. It is a synchronous FIFO of FDEPTH entries, each (DWIDTH+1) bits wide (data plus last flag), with an occupancy output used for the issue rule.

Test Plan:
- Basic drain: memory[1000..1003] = 5, −3, 7, 9; base_addr=1000, count=4, out_ready=1, start at cycle 0.
  - mem_re in cycles 1–4 at addresses 1000–1003.
  - out_valid in cycles 3–6 with data 5, −3, 7, 9.
  - out_last only in cycle 6; done in cycle 7.
- Backpressure: count=500, out_ready driven by a random 50% pattern.
  - All 500 words arrive in order, with no duplicates or drops.
  - FIFO occupancy never exceeds FDEPTH; data stays stable while stalled.
  - Exactly one out_last and one done.
- Zero count: start with count=0.
  - done=1 in cycle 1.
  - mem_re, out_valid and busy stay 0 throughout.
- Address wrap: IMGSIZE=12, base_addr=4094, count=4.
  - mem_addr sequence is 4094, 4095, 0, 1.
  - Data matches memory at those addresses.
- Reset and re-start:
  - Assert rst in the middle of a 10-word transfer: all outputs go to 0 asynchronously, and no done pulse occurs.
  - A new start with count=2 then completes normally.
- Start ignored when busy: a second start pulse during READ is ignored. Only the original word count is emitted, with a single done.

Source files
------------

// File: rtl/gobou_readout_pkg.sv
// Shared widths and the readout state encoding for the gobou result-drain engine.
package gobou_readout_pkg;

    localparam int GB_DWIDTH  = 16;
    localparam int GB_IMGSIZE = 12;
    localparam int GB_LWIDTH  = 10;
    localparam int GB_FDEPTH  = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } readout_state_e;

endpackage

// File: rtl/gobou_readout_fifo.sv
// Small synchronous FIFO holding {last, data} words between memory and the stream.
// Occupancy is exported so the issuer can reserve space before a read lands.
module gobou_readout_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [WIDTH-1:0]                 wr_data,
    input  logic                             rd_en,
    output logic [WIDTH-1:0]                 rd_data,
    output logic [$clog2(DEPTH+1)-1:0]       occupancy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    occ_q;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rd_data   = mem_q[rd_ptr];
    assign occupancy = occ_q;

    // Storage, pointers and occupancy; storage is cleared so outputs read 0 in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr] <= wr_data;
                wr_ptr        <= next_ptr(wr_ptr);
            end
            if (rd_en) rd_ptr <= next_ptr(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule

// File: rtl/gobou_readout.sv
// Result-drain engine: reads count words from image memory starting at base_addr
// and streams them out on valid/ready, flagging the last word and pulsing done.
//
//   state   | meaning
//   S_IDLE  | waiting for start; count=0 requests pulse done without reading
//   S_READ  | issuing memory reads while FIFO space is available
//   S_DRAIN | all reads issued; waiting for the last word to be accepted
module gobou_readout
    import gobou_readout_pkg::*;
#(
    parameter int DWIDTH  = GB_DWIDTH,
    parameter int IMGSIZE = GB_IMGSIZE,
    parameter int LWIDTH  = GB_LWIDTH,
    parameter int FDEPTH  = GB_FDEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [IMGSIZE-1:0]        base_addr,
    input  logic [LWIDTH-1:0]         count,
    output logic                      busy,
    output logic                      done,
    output logic                      mem_re,
    output logic [IMGSIZE-1:0]        mem_addr,
    input  logic signed [DWIDTH-1:0]  read_img,
    output logic                      out_valid,
    output logic signed [DWIDTH-1:0]  out_data,
    output logic                      out_last,
    input  logic                      out_ready
);

    localparam int CW = $clog2(FDEPTH + 1);

    readout_state_e    state;
    logic [LWIDTH-1:0] issue_left;
    logic [LWIDTH-1:0] pop_left;
    logic              in_flight;
    logic              in_flight_last;
    logic [CW-1:0]     fifo_occ;
    logic [DWIDTH:0]   fifo_rd;
    logic              pop;
    logic              slot_free;

    assign pop       = out_valid & out_ready;
    assign out_valid = (fifo_occ != '0);
    assign {out_last, out_data} = fifo_rd;

    // A read may issue only if its word is guaranteed a FIFO slot when it lands.
    assign slot_free = (int'(fifo_occ) + int'(in_flight)) < (FDEPTH + int'(pop));
    assign mem_re    = (state == S_READ) && slot_free;

    gobou_readout_fifo #(
        .WIDTH (DWIDTH + 1),
        .DEPTH (FDEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (in_flight),
        .wr_data   ({in_flight_last, read_img}),
        .rd_en     (pop),
        .rd_data   (fifo_rd),
        .occupancy (fifo_occ)
    );

    // Sequencer: latches the request, counts issues and pops, drives busy/done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            issue_left     <= '0;
            pop_left       <= '0;
            mem_addr       <= '0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            done           <= 1'b0;
            in_flight      <= mem_re;
            in_flight_last <= mem_re && (issue_left == LWIDTH'(1));
            if (mem_re) mem_addr <= mem_addr + 1'b1;
            if (pop) pop_left <= pop_left - 1'b1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        mem_addr   <= base_addr;
                        issue_left <= count;
                        pop_left   <= count;
                        if (count == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= S_READ;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (mem_re) begin
                        issue_left <= issue_left - 1'b1;
                        if (issue_left == LWIDTH'(1)) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // The last word leaving means the FIFO is empty and nothing is in flight.
                    if (pop && pop_left == LWIDTH'(1)) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gobou_readout.sv
// Directed bench for gobou_readout with a behavioural one-cycle-latency image memory.
module tb_gobou_readout;

    logic               clk;
    logic               rst;
    logic               start;
    logic [11:0]        base_addr;
    logic [9:0]         count;
    logic               busy;
    logic               done;
    logic               mem_re;
    logic [11:0]        mem_addr;
    logic signed [15:0] read_img;
    logic               out_valid;
    logic signed [15:0] out_data;
    logic               out_last;
    logic               out_ready;

    logic signed [15:0] img [0:4095];

    int checks = 0;
    int errors = 0;

    gobou_readout dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .read_img  (read_img),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Image memory model: data valid the cycle after mem_re.
    always @(posedge clk) begin
        if (mem_re) read_img <= img[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Runs one transfer and checks it black-box; optionally fires a second start during READ.
    task automatic run_stream(input int base, input int n, input bit rnd, input bit extra_start);
        int  popped, issued, dones, lasts, outstanding, max_out;
        bit  stalled, finished;
        logic signed [15:0] held_data;
        logic held_last;
        popped = 0; issued = 0; dones = 0; lasts = 0; outstanding = 0; max_out = 0;
        stalled = 0; finished = 0; held_data = '0; held_last = 0;
        @(negedge clk);
        base_addr = 12'(base);
        count     = 10'(n);
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (extra_start && cyc == 0) begin
                start     = 1'b1;
                base_addr = 12'd50;
                count     = 10'd3;
            end else begin
                start = 1'b0;
            end
            #1;
            if (done) begin
                dones++;
                finished = 1;
                check("busy_low_at_done", busy, 0);
            end
            if (mem_re) begin
                check("issue_addr", mem_addr, (base + issued) % 4096);
                issued++;
            end
            if (out_valid) begin
                if (stalled) begin
                    check("stall_data_stable", out_data, held_data);
                    check("stall_last_stable", out_last, held_last);
                end
                if (out_ready) begin
                    check("stream_data", out_data, img[(base + popped) % 4096]);
                    check("stream_last", out_last, (popped == n - 1));
                    if (out_last) lasts++;
                    popped++;
                end
            end
            stalled   = out_valid && !out_ready;
            held_data = out_data;
            held_last = out_last;
            outstanding = outstanding + int'(mem_re) - int'(out_valid && out_ready);
            if (outstanding > max_out) max_out = outstanding;
            if (!finished) @(negedge clk);
        end
        start = 1'b0;
        check("stream_finished", finished, 1);
        check("stream_words", popped, n);
        check("stream_issues", issued, n);
        check("stream_one_last", lasts, 1);
        check("stream_max_outstanding_le_fdepth", (max_out <= 2), 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            if (done) dones++;
        end
        check("stream_one_done", dones, 1);
        check("idle_busy", busy, 0);
        check("idle_valid", out_valid, 0);
    endtask

    initial begin
        int bd [4];
        bd = '{5, -3, 7, 9};
        for (int i = 0; i < 4096; i++) img[i] = 16'(i * 29 - 3000);
        for (int i = 0; i < 4; i++) img[1000 + i] = 16'(bd[i]);

        rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; out_ready = 1'b1; read_img = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem_re", mem_re, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic drain with exact cycle timing; start is high in cycle 0.
        @(negedge clk);
        base_addr = 12'd1000; count = 10'd4; start = 1'b1; out_ready = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            check($sformatf("basic_mem_re_c%0d", c), mem_re, (c >= 1 && c <= 4));
            if (c >= 1 && c <= 4) check($sformatf("basic_addr_c%0d", c), mem_addr, 1000 + c - 1);
            check($sformatf("basic_valid_c%0d", c), out_valid, (c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) check($sformatf("basic_data_c%0d", c), out_data, bd[c - 3]);
            check($sformatf("basic_last_c%0d", c), out_last, (c == 6));
            check($sformatf("basic_done_c%0d", c), done, (c == 7));
            check($sformatf("basic_busy_c%0d", c), busy, (c >= 1 && c <= 6));
        end

        // Zero count: done in cycle 1, nothing else moves.
        @(negedge clk);
        base_addr = 12'd7; count = 10'd0; start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            check($sformatf("zero_done_c%0d", c), done, (c == 1));
            check($sformatf("zero_busy_c%0d", c), busy, 0);
            check($sformatf("zero_mem_re_c%0d", c), mem_re, 0);
            check($sformatf("zero_valid_c%0d", c), out_valid, 0);
        end

        // Backpressure with random ready.
        run_stream(200, 500, 1'b1, 1'b0);

        // Address wrap, full-rate and stalled.
        run_stream(4094, 4, 1'b0, 1'b0);
        run_stream(4094, 4, 1'b1, 1'b0);

        // Second start during READ is ignored.
        run_stream(500, 6, 1'b0, 1'b1);

        // Reset in the middle of a 10-word transfer.
        @(negedge clk);
        base_addr = 12'd300; count = 10'd10; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_mem_re", mem_re, 0);
        check("abort_mem_addr", mem_addr, 0);
        check("abort_valid", out_valid, 0);
        check("abort_data", out_data, 0);
        check("abort_last", out_last, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            #1;
            check("abort_no_done", done, 0);
            check("abort_no_valid", out_valid, 0);
        end
        run_stream(300, 2, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
